// File: rtl/stopwatch_counter_pkg.sv
// Shared state encoding and BCD digit limits for the stopwatch counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DIGIT_MAX = 9;
  localparam int SEC_T_MAX = 5;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit of the stopwatch: counts 0..MAX on inc, wraps to 0 and
// raises a combinational carry for the next digit in the same cycle.
module bcd_digit #(
  parameter int MAX = 9,
  parameter int W   = 4
) (
  input  logic         clk_in,
  input  logic         res,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_value;

  always_ff @(posedge clk_in) begin
    if (!res || clr) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= (r_value == MAX_V) ? '0 : r_value + W'(1);
    end
  end

  assign value = r_value;
  assign carry = inc & (r_value == MAX_V);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch mm:ss.cc counter driven by the 100 Hz tick, with run/pause/clear FSM.
// Optional lap hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN_T   = 5
) (
  input  logic       clk_in,
  input  logic       res,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       running,
  output logic [2:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic [3:0] cs_t,
  output logic [3:0] cs_u,
  output logic [1:0] o_dbg_state
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  logic                   w_tick_pulse;
  state_t                 r_state;
  logic                   r_running;
  logic                   w_count;
  logic                   w_clr;
  logic                   w_c_cs_u, w_c_cs_t, w_c_sec_u, w_c_sec_t, w_c_min_u;
  logic                   w_unused_carry;
  logic [2:0]             w_min_t, w_sec_t;
  logic [3:0]             w_min_u, w_sec_u, w_cs_t, w_cs_u;
  logic [21:0]            w_live;

  // tick_in is treated as data: synchronise, then detect its rising edge only
  always_ff @(posedge clk_in) begin
    if (!res) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_tick_pulse = r_sync[SYNC_STAGES-1] & ~r_edge;

  always_ff @(posedge clk_in) begin
    if (!res) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start_stop) begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end
        RUN: if (start_stop) begin
          r_state   <= PAUSE;
          r_running <= 1'b0;
        end
        PAUSE: if (start_stop) begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end else if (clear) begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Decisions use the state at the start of the cycle, so a tick that lands
  // with start_stop in RUN is still counted before the pause takes effect.
  assign w_count = (r_state == RUN) & w_tick_pulse;
  assign w_clr   = (r_state == PAUSE) & clear & ~start_stop;

  bcd_digit #(.MAX(DIGIT_MAX), .W(4)) u_cs_u (
    .clk_in(clk_in), .res(res), .clr(w_clr), .inc(w_count),
    .value(w_cs_u), .carry(w_c_cs_u));
  bcd_digit #(.MAX(DIGIT_MAX), .W(4)) u_cs_t (
    .clk_in(clk_in), .res(res), .clr(w_clr), .inc(w_c_cs_u),
    .value(w_cs_t), .carry(w_c_cs_t));
  bcd_digit #(.MAX(DIGIT_MAX), .W(4)) u_sec_u (
    .clk_in(clk_in), .res(res), .clr(w_clr), .inc(w_c_cs_t),
    .value(w_sec_u), .carry(w_c_sec_u));
  bcd_digit #(.MAX(SEC_T_MAX), .W(3)) u_sec_t (
    .clk_in(clk_in), .res(res), .clr(w_clr), .inc(w_c_sec_u),
    .value(w_sec_t), .carry(w_c_sec_t));
  bcd_digit #(.MAX(DIGIT_MAX), .W(4)) u_min_u (
    .clk_in(clk_in), .res(res), .clr(w_clr), .inc(w_c_sec_t),
    .value(w_min_u), .carry(w_c_min_u));
  bcd_digit #(.MAX(MAX_MIN_T), .W(3)) u_min_t (
    .clk_in(clk_in), .res(res), .clr(w_clr), .inc(w_c_min_u),
    .value(w_min_t), .carry(w_unused_carry));

  assign w_live = {w_min_t, w_min_u, w_sec_t, w_sec_u, w_cs_t, w_cs_u};

`ifdef STOPWATCH_LAP_EN
  logic        r_lap_hold;
  logic [21:0] r_snap;

  // First lap in RUN freezes the display; the next lap in any state releases it
  always_ff @(posedge clk_in) begin
    if (!res || w_clr) begin
      r_lap_hold <= 1'b0;
      r_snap     <= '0;
    end else if (lap) begin
      if (r_lap_hold) begin
        r_lap_hold <= 1'b0;
      end else if (r_state == RUN) begin
        r_lap_hold <= 1'b1;
        r_snap     <= w_live;
      end
    end
  end

  assign {min_t, min_u, sec_t, sec_u, cs_t, cs_u} = r_lap_hold ? r_snap : w_live;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign {min_t, min_u, sec_t, sec_u, cs_t, cs_u} = w_live;
`endif

  assign running     = r_running;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed scoreboard bench for stopwatch_counter; the driver queues expected
// display/state words with the cycle at which they must appear.
module tb_stopwatch_counter;
  import stopwatch_pkg::*;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       tick_in = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic       running;
  logic [2:0] min_t, sec_t;
  logic [3:0] min_u, sec_u, cs_t, cs_u;
  logic [1:0] dbg_state;

  stopwatch_counter #(.SYNC_STAGES(2), .MAX_MIN_T(5)) dut (
    .clk_in(clk), .res(res), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .lap(lap), .running(running),
    .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
    .cs_t(cs_t), .cs_u(cs_u), .o_dbg_state(dbg_state));

  // clock/reset block
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [24:0] exp_q[$];
  int unsigned at_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [24:0] m_exp;
  string       m_nm;
  logic [24:0] w_act;

  assign w_act = {dbg_state, running, min_t, min_u, sec_t, sec_u, cs_t, cs_u};

  function automatic logic [24:0] pk(input logic [1:0] st, input logic run,
                                     input int mt, input int mu, input int s_t,
                                     input int su, input int ct, input int cu);
    return {st, run, 3'(mt), 4'(mu), 3'(s_t), 4'(su), 4'(ct), 4'(cu)};
  endfunction

  task automatic expect_at(input string nm, input int unsigned dly, input logic [24:0] e);
    exp_q.push_back(e);
    at_q.push_back(cyc + dly);
    name_q.push_back(nm);
  endtask

  // monitor
  always @(negedge clk) begin
    while (at_q.size() > 0 && at_q[0] <= cyc) begin
      m_exp = exp_q.pop_front();
      void'(at_q.pop_front());
      m_nm = name_q.pop_front();
      checks++;
      if (w_act !== m_exp) begin
        errors++;
        $display("FAIL %s: got st=%0d run=%0d %0d%0d:%0d%0d.%0d%0d want st=%0d run=%0d %0d%0d:%0d%0d.%0d%0d",
                 m_nm, w_act[24:23], w_act[22], w_act[21:19], w_act[18:15], w_act[14:12],
                 w_act[11:8], w_act[7:4], w_act[3:0], m_exp[24:23], m_exp[22], m_exp[21:19],
                 m_exp[18:15], m_exp[14:12], m_exp[11:8], m_exp[7:4], m_exp[3:0]);
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; step(1); start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; step(1); lap = 1'b0;
  endtask

  task automatic tick();
    tick_in = 1'b1; step(2); tick_in = 1'b0; step(2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: cycle %0d reached, bench did not complete", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b0;
    step(3);
    expect_at("reset", 0, pk(IDLE, 0, 0, 0, 0, 0, 0, 0));
    res = 1'b1;
    step(1);

    ticks(3);
    pulse_clr();
    expect_at("idle_no_count", 0, pk(IDLE, 0, 0, 0, 0, 0, 0, 0));

    pulse_ss();
    expect_at("start", 0, pk(RUN, 1, 0, 0, 0, 0, 0, 0));

    tick_in = 1'b1;
    expect_at("tick_lat2", 2, pk(RUN, 1, 0, 0, 0, 0, 0, 0));
    expect_at("tick_lat3", 3, pk(RUN, 1, 0, 0, 0, 0, 0, 1));
    step(2); tick_in = 1'b0; step(2);

    ticks(5998);
    expect_at("t_00_59_99", 0, pk(RUN, 1, 0, 0, 5, 9, 9, 9));
    tick();
    expect_at("t_01_00_00", 0, pk(RUN, 1, 0, 1, 0, 0, 0, 0));

    pulse_clr();
    expect_at("run_clear_ignored", 0, pk(RUN, 1, 0, 1, 0, 0, 0, 0));

    // start_stop on the tick_pulse cycle in RUN
    tick_in = 1'b1; step(2);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    tick_in = 1'b0; step(2);
    expect_at("run_ss_tick", 0, pk(PAUSE, 0, 0, 1, 0, 0, 0, 1));

    tick();
    expect_at("pause_no_count", 0, pk(PAUSE, 0, 0, 1, 0, 0, 0, 1));

    // start_stop + clear on the tick_pulse cycle in PAUSE
    tick_in = 1'b1; step(2);
    start_stop = 1'b1; clear = 1'b1; step(1); start_stop = 1'b0; clear = 1'b0;
    tick_in = 1'b0; step(2);
    expect_at("pause_ss_clear", 0, pk(RUN, 1, 0, 1, 0, 0, 0, 1));

    pulse_ss();
    pulse_clr();
    expect_at("pause_clear_a", 0, pk(IDLE, 0, 0, 0, 0, 0, 0, 0));

    pulse_ss();
    ticks(1234);
    pulse_ss();
    expect_at("pause_12_34", 0, pk(PAUSE, 0, 0, 0, 1, 2, 3, 4));
    pulse_clr();
    expect_at("pause_clear_b", 0, pk(IDLE, 0, 0, 0, 0, 0, 0, 0));

    // wrap: preload 59:59.99 while paused
    pulse_ss();
    pulse_ss();
    dut.u_min_t.r_value = 3'd5;
    dut.u_min_u.r_value = 4'd9;
    dut.u_sec_t.r_value = 3'd5;
    dut.u_sec_u.r_value = 4'd9;
    dut.u_cs_t.r_value  = 4'd9;
    dut.u_cs_u.r_value  = 4'd9;
    step(1);
    expect_at("preset_59_59_99", 0, pk(PAUSE, 0, 5, 9, 5, 9, 9, 9));
    pulse_ss();
    tick();
    expect_at("wrap", 0, pk(RUN, 1, 0, 0, 0, 0, 0, 0));
    tick();
    expect_at("after_wrap", 0, pk(RUN, 1, 0, 0, 0, 0, 0, 1));

    ticks(2);
    res = 1'b0;
    step(1);
    expect_at("reset_mid", 0, pk(IDLE, 0, 0, 0, 0, 0, 0, 0));
    res = 1'b1;
    step(1);

    pulse_ss();
    ticks(100);
    expect_at("t_00_01_00", 0, pk(RUN, 1, 0, 0, 0, 1, 0, 0));
    pulse_lap();
    ticks(50);
`ifdef STOPWATCH_LAP_EN
    expect_at("lap_hold", 0, pk(RUN, 1, 0, 0, 0, 1, 0, 0));
`else
    expect_at("lap_ignored", 0, pk(RUN, 1, 0, 0, 0, 1, 5, 0));
`endif
    pulse_lap();
    expect_at("lap_release", 0, pk(RUN, 1, 0, 0, 0, 1, 5, 0));

`ifdef STOPWATCH_LAP_EN
    pulse_ss();
    pulse_lap();
    pulse_ss();
    tick();
    expect_at("lap_pause_ignored", 0, pk(RUN, 1, 0, 0, 0, 1, 5, 1));
    pulse_lap();
    pulse_ss();
    pulse_clr();
    expect_at("clear_drops_lap", 0, pk(IDLE, 0, 0, 0, 0, 0, 0, 0));
    pulse_ss();
    tick();
    expect_at("live_after_clear", 0, pk(RUN, 1, 0, 0, 0, 0, 0, 1));
`endif

    step(3);
    if (at_q.size() != 0) begin
      errors += at_q.size();
      $display("FAIL pending: %0d queued checks never reached", at_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
